// File: rtl/tt_selftest_driver.sv
// Self-test engine: resets the DUT, drives LFSR vectors, folds responses
// into a 16-bit MISR and flags whether the final signature matches.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   ena             advance when high, freeze everything when low
//   start           one-cycle run request (taken only when idle)
//   stim_out        vector to DUT ui_in
//   resp_in         DUT uo_out
//   dut_rst_n       DUT active-low reset
//   busy, done      run in progress / run complete (sticky)
//   pass            signature == GOLDEN_SIG, valid with done
//   signature       current MISR value
module tt_selftest_driver #(
    parameter int          NUM_VECTORS = 256,
    parameter int          LAT         = 1,
    parameter int          RST_CYCLES  = 4,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    output logic [7:0]  stim_out,
    input  logic [7:0]  resp_in,
    output logic        dut_rst_n,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    // Completion folds straight into the return to IDLE, so there is
    // no separately registered DONE state.
    typedef enum logic [1:0] {
        IDLE,
        RESET_DUT,
        RUN,
        DRAIN
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] NV_LAST  = 16'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cap_cnt_q, cap_cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  stim_q, stim_d;
    logic        rstn_q, rstn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] sig_q, sig_d;
    logic        in_run;
    logic        cap;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s,
                                              input logic [7:0]  r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
               ^ {8'h00, r};
    endfunction

    assign in_run = (state_q == RUN);

    // A sample is due LAT active cycles after each RUN cycle; the delay
    // line only moves with ena so sampling stays aligned with the DUT.
    if (LAT == 0) begin : g_nolat
        assign cap = in_run;
    end else begin : g_lat
        logic [LAT-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (ena) begin
                pipe_d = LAT'({pipe_q, in_run});
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign cap = pipe_q[LAT-1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_cnt_d = cap_cnt_q;
        lfsr_d    = lfsr_q;
        stim_d    = stim_q;
        rstn_d    = rstn_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        sig_d     = sig_q;

        if (ena) begin
            if (cap) begin
                sig_d     = misr_next(sig_q, resp_in);
                cap_cnt_d = (cap_cnt_q == NV_LAST) ? 16'd0
                                                   : cap_cnt_q + 16'd1;
            end

            unique case (state_q)
                IDLE: begin
                    rstn_d = 1'b1;
                    if (start) begin
                        state_d   = RESET_DUT;
                        cnt_d     = 16'd0;
                        cap_cnt_d = 16'd0;
                        rstn_d    = 1'b0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        sig_d     = 16'h0000;
                        lfsr_d    = SEED;
                        stim_d    = 8'h00;
                    end
                end
                RESET_DUT: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = RUN;
                        cnt_d   = 16'd0;
                        rstn_d  = 1'b1;
                        stim_d  = lfsr_q;
                        lfsr_d  = lfsr_next(lfsr_q);
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                RUN: begin
                    if (cnt_q == NV_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = 16'd0;
                        stim_d  = 8'h00;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        stim_d = lfsr_q;
                        lfsr_d = lfsr_next(lfsr_q);
                    end
                end
                DRAIN: begin
                    stim_d = 8'h00;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // The last sample ends the run, whether it lands in RUN
            // (LAT=0) or at the end of DRAIN.
            if (cap && (cap_cnt_q == NV_LAST)) begin
                state_d = IDLE;
                stim_d  = 8'h00;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (sig_d == GOLDEN_SIG);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            cap_cnt_q <= 16'd0;
            lfsr_q    <= SEED;
            stim_q    <= 8'h00;
            rstn_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            sig_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_cnt_q <= cap_cnt_d;
            lfsr_q    <= lfsr_d;
            stim_q    <= stim_d;
            rstn_q    <= rstn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            sig_q     <= sig_d;
        end
    end

    assign stim_out  = stim_q;
    assign dut_rst_n = rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_tt_selftest_driver.sv
// Bench for tt_selftest_driver: several configurations share one stimulus
// stream and are compared every cycle against a run-timeline model.
module tb_tt_selftest_driver;

    localparam int N = 5;
    localparam int NV_P [N] = '{4, 2, 2, 256, 37};
    localparam int LAT_P [N] = '{1, 0, 0, 2, 3};
    localparam int RST_P [N] = '{4, 4, 4, 4, 7};
    localparam logic [7:0] SEED_P [N] =
        '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h1F};
    localparam logic [15:0] GOLD_P [N] =
        '{16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  resp [N];
    logic [7:0]  stim_w [N];
    logic        rstn_w [N];
    logic        busy_w [N];
    logic        done_w [N];
    logic        pass_w [N];
    logic [15:0] sig_w [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        tt_selftest_driver #(
            .NUM_VECTORS(NV_P[g]),
            .LAT        (LAT_P[g]),
            .RST_CYCLES (RST_P[g]),
            .SEED       (SEED_P[g]),
            .GOLDEN_SIG (GOLD_P[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .start    (start),
            .stim_out (stim_w[g]),
            .resp_in  (resp[g]),
            .dut_rst_n(rstn_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .pass     (pass_w[g]),
            .signature(sig_w[g])
        );
    end

    // Model: a run is a timeline of k active cycles after the start edge.
    bit          m_act [N];
    int          m_k [N];
    logic        m_done [N];
    logic        m_pass [N];
    logic        m_rstn [N];
    logic [15:0] m_sig [N];
    logic [7:0]  vec [N][256];
    logic [7:0]  h1, h2;
    logic [15:0] gold3;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [7:0] lfsr_nx(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s,
                                         input logic [7:0]  r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
               ^ {8'h00, r};
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %h want %h",
                     nm, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = 1'b0;
            m_k[i]    = 0;
            m_done[i] = 1'b0;
            m_pass[i] = 1'b0;
            m_rstn[i] = 1'b0;
            m_sig[i]  = 16'h0000;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int r, nv, l;
            r  = RST_P[i];
            nv = NV_P[i];
            l  = LAT_P[i];
            if (ena) begin
                if (m_act[i]) begin
                    if (m_k[i] >= r + 1 + l && m_k[i] <= r + nv + l)
                        m_sig[i] = misr(m_sig[i], resp[i]);
                    m_k[i]++;
                    if (m_k[i] > r + nv + l) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                        m_pass[i] = (m_sig[i] == GOLD_P[i]);
                    end
                end else begin
                    m_rstn[i] = 1'b1;
                    if (start) begin
                        m_act[i]  = 1'b1;
                        m_k[i]    = 1;
                        m_done[i] = 1'b0;
                        m_pass[i] = 1'b0;
                        m_sig[i]  = 16'h0000;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic [7:0] es;
            logic       er;
            int         r;
            r  = RST_P[i];
            es = 8'h00;
            er = m_rstn[i];
            if (m_act[i]) begin
                er = (m_k[i] > r);
                if (m_k[i] > r && m_k[i] <= r + NV_P[i])
                    es = vec[i][m_k[i] - r - 1];
            end
            chk("stim", i, {8'h00, stim_w[i]}, {8'h00, es});
            chk("dut_rst_n", i, {15'h0, rstn_w[i]}, {15'h0, er});
            chk("busy", i, {15'h0, busy_w[i]}, {15'h0, m_act[i]});
            chk("done", i, {15'h0, done_w[i]}, {15'h0, m_done[i]});
            chk("pass", i, {15'h0, pass_w[i]}, {15'h0, m_pass[i]});
            chk("sig", i, sig_w[i], m_sig[i]);
        end
    endtask

    // Called at a negedge: drive inputs, predict the edge, then check.
    task automatic tick(input logic e, input logic s);
        ena      = e;
        start    = s;
        resp[0]  = 8'h00;
        resp[1]  = 8'h01;
        resp[2]  = 8'h01;
        resp[3]  = h2;
        resp[4]  = 8'($urandom);
        if (e) begin
            h2 = h1;
            h1 = stim_w[3];
        end
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to_done(input bit rnd, input int fa,
                               input int budget);
        int c;
        c = 0;
        while (!(done_w[3] === 1'b1 && busy_w[3] === 1'b0)
               && c < budget) begin
            logic e, s;
            e = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            s = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
            if (c >= fa && c < fa + 10) begin
                e = 1'b0;
                s = (c == fa + 3);
            end
            tick(e, s);
            c++;
        end
        if (c >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done after %0d cycles", c);
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        h1 = 8'h00;
        h2 = 8'h00;
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, first;
        for (int i = 0; i < N; i++) begin
            vec[i][0] = SEED_P[i];
            for (int n = 1; n < 256; n++)
                vec[i][n] = lfsr_nx(vec[i][n-1]);
            resp[i] = 8'h00;
        end
        gold3 = 16'h0000;
        for (int n = 0; n < 256; n++)
            gold3 = misr(gold3, vec[3][n]);
        h1 = 8'h00;
        h2 = 8'h00;
        model_reset();

        chk("vec1", 0, {8'h00, vec[0][1]}, 16'h00EA);
        chk("vec2", 0, {8'h00, vec[0][2]}, 16'h0075);
        chk("vec3", 0, {8'h00, vec[0][3]}, 16'h0082);
        chk("vec255", 3, {8'h00, vec[3][255]}, 16'h00A5);

        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        tick(1'b1, 1'b1);
        cnt   = 0;
        first = -1;
        while (!(done_w[3] === 1'b1) && cnt < 400) begin
            tick(1'b1, 1'b0);
            cnt++;
            if (done_w[0] === 1'b1 && first < 0) first = cnt;
        end
        chk("latency", 0, 16'(first), 16'd9);
        chk("lit_sig", 0, sig_w[0], 16'h0000);
        chk("lit_pass", 0, {15'h0, pass_w[0]}, 16'h0001);
        chk("lit_sig", 1, sig_w[1], 16'h0003);
        chk("lit_pass", 1, {15'h0, pass_w[1]}, 16'h0001);
        chk("lit_sig", 2, sig_w[2], 16'h0003);
        chk("lit_pass", 2, {15'h0, pass_w[2]}, 16'h0000);
        chk("gold_sig", 3, sig_w[3], gold3);
        chk("done_seen", 3, {15'h0, done_w[3]}, 16'h0001);

        tick(1'b1, 1'b1);
        chk("b2b_done", 3, {15'h0, done_w[3]}, 16'h0000);
        run_to_done(1'b1, 60, 2000);
        chk("frozen_run_sig", 3, sig_w[3], gold3);

        tick(1'b1, 1'b1);
        for (int i = 0; i < 100; i++)
            tick($urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0);
        async_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        run_to_done(1'b1, 1000000, 2000);
        chk("rerun_sig", 3, sig_w[3], gold3);

        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
